// File: rtl/ula_pkg.sv
// Shared ULA arithmetic definitions.
// Holds the FSM encoding and default operand/result widths.
package ula_pkg;

  localparam int ULA_WIDTH     = 4;
  localparam int ULA_OUT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder_1bit.sv
// Gate-level 1-bit full adder cell.
// Additive counterpart of the 1-bit subtractor cell.
module full_adder_1bit (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Cout,
  output logic S
);

  logic ab_x;
  logic ab_a;
  logic cx_a;

  xor g_x0 (ab_x, A, B);
  xor g_x1 (S, ab_x, Cin);
  and g_a0 (ab_a, A, B);
  and g_a1 (cx_a, ab_x, Cin);
  or  g_o0 (Cout, ab_a, cx_a);

endmodule

// File: rtl/serial_adder_4bit.sv
// Bit-serial adder: one full-adder pass per clock, LSB first.
// Start/Busy/Done handshake; result registers hold until next completion.
module serial_adder_4bit
  import ula_pkg::*;
#(
  parameter int WIDTH     = ULA_WIDTH,
  parameter int OUT_WIDTH = ULA_OUT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Start,
  input  logic                 Ack,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic                 Cin,
  output logic                 Busy,
  output logic                 Done,
  output logic [OUT_WIDTH-1:0] S,
  output logic                 Cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t state;
  state_t next;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] r_sh;
  logic [WIDTH-1:0] s_q;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             cout_q;
  logic             fa_s;
  logic             fa_co;
  logic             accept;
  logic             last;
  logic [WIDTH-1:0] r_next;

  full_adder_1bit u_fa (
    .A    (a_sh[0]),
    .B    (b_sh[0]),
    .Cin  (carry),
    .Cout (fa_co),
    .S    (fa_s)
  );

  assign accept = Start && (state == IDLE || state == DONE);
  assign last   = (state == RUN) && (cnt == CW'(WIDTH - 1));
  assign r_next = {fa_s, r_sh};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:    if (Start) next = RUN;
      RUN:     if (last) next = DONE;
      DONE: begin
        if (Start)    next = RUN;
        else if (Ack) next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  always_comb begin
    Busy = (state == RUN);
    Done = (state == DONE);
  end

  // Datapath: operands shift right, sum bits enter r_sh from the top.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      r_sh   <= '0;
      s_q    <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
    end else if (accept) begin
      a_sh  <= A;
      b_sh  <= B;
      carry <= Cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      r_sh  <= r_next[WIDTH-1:1];
      carry <= fa_co;
      cnt   <= cnt + 1'b1;
      if (last) begin
        s_q    <= r_next;
        cout_q <= fa_co;
      end
    end
  end

  assign S    = {{(OUT_WIDTH - WIDTH){1'b0}}, s_q};
  assign Cout = cout_q;

endmodule

// File: tb/tb_serial_adder_4bit.sv
// Directed bench for serial_adder_4bit.
// Vector table plus hand-written handshake and reset sequences.
module tb_serial_adder_4bit;

  logic       clk;
  logic       rst;
  logic       Start;
  logic       Ack;
  logic [3:0] A;
  logic [3:0] B;
  logic       Cin;
  logic       Busy;
  logic       Done;
  logic [7:0] S;
  logic       Cout;

  int checks;
  int errors;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [7:0] s;
    logic       cout;
  } vec_t;

  vec_t vecs [6];

  serial_adder_4bit dut (
    .clk   (clk),
    .rst   (rst),
    .Start (Start),
    .Ack   (Ack),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .Busy  (Busy),
    .Done  (Done),
    .S     (S),
    .Cout  (Cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge inside RUN; returns at the first negedge
  // where Busy is low, counting the Busy cycles seen.
  task automatic count_busy(input int already, output int n);
    n = already;
    for (int i = 0; i < 12; i++) begin
      chk("upper_zero", {28'd0, S[7:4]}, 32'd0);
      chk("busy_done_excl", {31'd0, Busy & Done}, 32'd0);
      if (!Busy) break;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic launch(input logic [3:0] a, input logic [3:0] b,
                        input logic cin);
    A = a; B = b; Cin = cin; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
  endtask

  task automatic finish_op(input string tag, input logic [7:0] s,
                           input logic c, input int nbusy);
    chk({tag, "_busy_cycles"}, nbusy, 4);
    chk({tag, "_done"}, {31'd0, Done}, 32'd1);
    chk({tag, "_s"}, {24'd0, S}, {24'd0, s});
    chk({tag, "_cout"}, {31'd0, Cout}, {31'd0, c});
  endtask

  task automatic ack_op(input string tag, input logic [7:0] s);
    Ack = 1'b1;
    @(negedge clk);
    Ack = 1'b0;
    chk({tag, "_idle_done"}, {31'd0, Done}, 32'd0);
    chk({tag, "_idle_busy"}, {31'd0, Busy}, 32'd0);
    chk({tag, "_hold_s"}, {24'd0, S}, {24'd0, s});
  endtask

  int n;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; Start = 1'b0; Ack = 1'b0;
    A = '0; B = '0; Cin = 1'b0;

    vecs[0] = '{4'd5,  4'd3, 1'b0, 8'h08, 1'b0};
    vecs[1] = '{4'd5,  4'd4, 1'b0, 8'h09, 1'b0};
    vecs[2] = '{4'd15, 4'd15, 1'b1, 8'h0F, 1'b1};
    vecs[3] = '{4'd15, 4'd1, 1'b0, 8'h00, 1'b1};
    vecs[4] = '{4'd7,  4'd8, 1'b1, 8'h00, 1'b1};
    vecs[5] = '{4'd10, 4'd4, 1'b1, 8'h0F, 1'b0};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_done", {31'd0, Done}, 32'd0);
    chk("rst_s", {24'd0, S}, 32'd0);
    chk("rst_cout", {31'd0, Cout}, 32'd0);

    // Stay idle without Start
    @(negedge clk);
    chk("idle_stay", {31'd0, Busy | Done}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      launch(vecs[i].a, vecs[i].b, vecs[i].cin);
      count_busy(0, n);
      finish_op($sformatf("vec%0d", i), vecs[i].s, vecs[i].cout, n);
      // DONE holds without Ack
      @(negedge clk);
      chk($sformatf("vec%0d_done_hold", i), {31'd0, Done}, 32'd1);
      chk($sformatf("vec%0d_s_hold", i), {24'd0, S}, {24'd0, vecs[i].s});
      ack_op($sformatf("vec%0d", i), vecs[i].s);
    end

    // Start re-asserted mid-RUN and operands zeroed: latched values win
    A = 4'd9; B = 4'd6; Cin = 1'b0; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    @(negedge clk);
    Start = 1'b1; A = 4'd0; B = 4'd0; Cin = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    count_busy(2, n);
    finish_op("midrun", 8'h0F, 1'b0, n);
    @(negedge clk);
    chk("midrun_no_queue_busy", {31'd0, Busy}, 32'd0);
    chk("midrun_no_queue_done", {31'd0, Done}, 32'd1);

    // Start+Ack in DONE: back-to-back op, no IDLE cycle
    A = 4'd2; B = 4'd2; Cin = 1'b0; Start = 1'b1; Ack = 1'b1;
    @(negedge clk);
    Start = 1'b0; Ack = 1'b0;
    chk("b2b_busy_now", {31'd0, Busy}, 32'd1);
    count_busy(0, n);
    finish_op("b2b", 8'h04, 1'b0, n);
    ack_op("b2b", 8'h04);

    // Reset during the second RUN cycle discards the op
    launch(4'd3, 4'd4, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", {31'd0, Busy}, 32'd0);
    chk("midrst_done", {31'd0, Done}, 32'd0);
    chk("midrst_s", {24'd0, S}, 32'd0);
    chk("midrst_cout", {31'd0, Cout}, 32'd0);
    repeat (5) begin
      @(negedge clk);
      chk("midrst_no_done", {31'd0, Done | Busy}, 32'd0);
    end
    launch(4'd6, 4'd7, 1'b0);
    count_busy(0, n);
    finish_op("postrst", 8'h0D, 1'b0, n);
    ack_op("postrst", 8'h0D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder_4bit.md
Name: serial_adder_4bit

Overview:
- Multi-cycle, bit-serial 4-bit adder for the ULA datapath.
- It is the inverse of the ripple subtractor: it reconstructs the minuend from a difference and a subtrahend (A = S + B), and it also serves as the ULA's sequential ADD unit.
- Processes one bit per clock through a single 1-bit full adder, using a start/busy/done handshake.
- Result format matches the subtractor: 8-bit S with the upper nibble forced to 0, plus a separate Cout.

Parameters:
- WIDTH, 4, operand width in bits; the number of serial add cycles.
- OUT_WIDTH, 8, result port width; bits OUT_WIDTH-1..WIDTH are always 0.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- Start  input  1  request; sampled only in IDLE or DONE.
- Ack  input  1  result consumed; sampled only in DONE.
- A  input  WIDTH  augend; latched when Start is accepted.
- B  input  WIDTH  addend; latched when Start is accepted.
- Cin  input  1  carry-in; latched when Start is accepted.
- Busy  output  1  high while in RUN.
- Done  output  1  high while in DONE; S and Cout are valid.
- S  output  OUT_WIDTH  sum; bits [WIDTH-1:0] hold the result, upper bits are constant 0.
- Cout  output  1  carry out of bit WIDTH-1.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; Busy=0, Done=0, S=0, Cout=0; shift registers, carry flop and bit counter cleared.
- Reset takes priority over every other input, including mid-RUN: the in-flight operation is discarded and no Done is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Start=1 → load a_sh=A, b_sh=B, carry=Cin, cnt=0; go to RUN.
  - Start=0 → stay in IDLE.
- RUN, each edge:
  - sum_bit = a_sh[0]^b_sh[0]^carry.
  - carry = majority(a_sh[0], b_sh[0], carry).
  - Shift sum_bit into the MSB of r_sh; shift a_sh and b_sh right.
  - cnt++.
  - When cnt reaches WIDTH-1: go to DONE, S[WIDTH-1:0]=final r_sh, Cout=final carry.
- Latency: accepting edge e0; bits 0..WIDTH-1 are processed on edges e1..eWIDTH; Done=1 directly after edge eWIDTH (4 cycles after accept for WIDTH=4).
- Busy=1 exactly WIDTH cycles per operation.
- Start during RUN is ignored and is not queued.
- A, B and Cin changes during RUN have no effect.
- DONE:
  - Done=1; S and Cout are held stable.
  - Start=1 → accepted as in IDLE (implicit Ack); go to RUN. Enables back-to-back operations with one DONE cycle between them.
  - Start=0, Ack=1 → go to IDLE.
  - Start=1 and Ack=1 together → Start wins (new operation).
  - Neither → stay in DONE indefinitely.
- S and Cout update only on the transition into DONE; they keep the last result through IDLE and RUN until the next completion or reset.
- Arithmetic is unsigned modulo 2^WIDTH, with overflow reported in Cout: {Cout, S[WIDTH-1:0]} = A + B + Cin, maximum 2*(2^WIDTH-1)+1.
- Done and Busy are never high in the same cycle.

Decomposition:
- Shared package (ula_pkg):
  - State encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2. The unused encoding 2'd3 returns to IDLE.
  - WIDTH/OUT_WIDTH defaults, shared with the other ULA arithmetic blocks.
- Sub-module: full_adder_1bit (A, B, Cin, Cout, S), gate-level, the additive counterpart of the existing 1-bit subtractor cell. Instantiated once and fed from the shift-register LSBs and the carry flop.
- Top-level contents: FSM, counter, shift registers, output registers, and the constant-zero upper S bits.

Test Plan:
- A=5, B=3, Cin=0, Start for 1 cycle → Busy for 4 cycles, then Done=1 with S=8'h08, Cout=0. Ack → IDLE, and S stays 8'h08.
- Inverse check: A=5 (difference of 9-4), B=4, Cin=0 → S=8'h09, Cout=0. Also A=15, B=15, Cin=1 → S=8'h0F, Cout=1.
- A=15, B=1, Cin=0 → S=8'h00, Cout=1 (wrap-around). S[7:4]=0 in every cycle of every test.
- Start=1 on the accept edge and again mid-RUN, with A/B changed to 0 mid-RUN → exactly one operation runs and the result reflects the latched operands.
- In DONE, hold Ack=1 and Start=1 together with A=2, B=2 → a new RUN starts, and Done reasserts 4 cycles later with S=8'h04 and no extra IDLE cycle.
- rst=1 on the second RUN cycle → the next cycle shows IDLE, Busy=0, Done=0, S=0, Cout=0. A following Start runs normally.
